// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_mmio_pkg: register map, STATUS layout and TX FSM states.
// Rev 1.0
// ------------------------------------------------------------------
package uart_tx_mmio_pkg;

  localparam logic [63:0] ART_BASE = 64'h0000_0000_1000_0000;
  localparam logic [63:0] KEY_BASE = 64'h0000_0000_1000_0100;

  localparam logic [4:0] OFF_TXDATA = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h10;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [63:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       ovf,
    input logic [7:0] count
  );
    logic [63:0] s;
    s                       = '0;
    s[STAT_FULL]            = full;
    s[STAT_EMPTY]           = empty;
    s[STAT_BUSY]            = busy;
    s[STAT_OVF]             = ovf;
    s[STAT_CNT_LSB +: 8]    = count;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_mmio_sync_fifo: parameterised circular-buffer FIFO.
// Rev 1.0
// ------------------------------------------------------------------
module uart_tx_mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // One extra pointer bit distinguishes full from empty when indices match.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with FIFO and irq.
// Rev 1.0
// ------------------------------------------------------------------
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = ART_BASE,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        tx,
  output logic        irq
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] CPB_M1 = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic [63:0] rdata_q, rdata_d;

  logic          hit;
  logic [4:0]    off;
  logic          wr_hit;
  logic          push;
  logic          pop;
  logic          status_rd;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [8:0]    count9;
  logic          busy;
  logic          baud_done;
  logic [63:0]   status_word;
  logic          unused_bits;

  uart_tx_mmio_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (bus_write_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign count9      = 9'(fifo_count);
  assign busy        = (state_q != TX_IDLE);
  assign baud_done   = (baud_q == CPB_M1);
  assign status_word = pack_status(fifo_full, fifo_empty, busy, ovf_q, count9[7:0]);
  assign unused_bits = ^{bus_write_data[63:8], count9[8]};

  // Register decode; a simultaneous write wins and the read is dropped.
  always_comb begin
    hit       = (bus_address[63:5] == BASE_ADDR[63:5]);
    off       = bus_address[4:0];
    wr_hit    = bus_write_enable & hit;
    push      = wr_hit && (off == OFF_TXDATA);
    irq_en_d  = irq_en_q;
    rdata_d   = rdata_q;
    status_rd = 1'b0;

    if (wr_hit && (off == OFF_CTRL)) begin
      irq_en_d = bus_write_data[0];
    end

    if (bus_read_enable && !bus_write_enable) begin
      rdata_d = '0;
      if (hit) begin
        case (off)
          OFF_STATUS: begin
            rdata_d   = status_word;
            status_rd = 1'b1;
          end
          OFF_CTRL: rdata_d = {63'd0, irq_en_q};
          default:  rdata_d = '0;
        endcase
      end
    end

    ovf_d = ovf_q;
    if (status_rd) begin
      ovf_d = 1'b0;
    end
    if (push && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx      = 1'b1;

    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_DATA: begin
        tx = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_read_data = rdata_q;
  assign irq           = irq_en_q & fifo_empty & ~busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_tx_mmio: randomized bench against a frame-level reference model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_tx_mmio;

  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        tx;
  logic        irq;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .tx               (tx),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued bytes, remaining cycles of the frame in flight.
  logic [7:0]  m_q[$];
  int          m_left;
  logic [7:0]  m_cur;
  logic        m_ovf;
  logic        m_irq_en;
  logic [63:0] m_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_tx();
    int pos;
    int slot;
    if (m_left == 0) return 1'b1;
    pos  = FRAME - m_left;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
    return 1'b1;
  endfunction

  function automatic logic m_irq();
    return m_irq_en && (m_q.size() == 0) && (m_left == 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_left   = 0;
    m_cur    = 8'd0;
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    m_rdata  = 64'd0;
  endtask

  task automatic model_edge();
    int          sz;
    logic        bsy;
    logic [63:0] st;
    logic        hit;
    logic [4:0]  off;
    sz  = m_q.size();
    bsy = (m_left != 0);
    st        = 64'd0;
    st[0]     = (sz == DEPTH);
    st[1]     = (sz == 0);
    st[2]     = bsy;
    st[3]     = m_ovf;
    st[15:8]  = 8'(sz);
    hit = (bus_address[63:5] == BASE[63:5]);
    off = bus_address[4:0];
    if (m_left != 0) m_left--;
    else if (sz != 0) begin
      m_cur  = m_q.pop_front();
      m_left = FRAME;
    end
    if (bus_write_enable) begin
      if (hit && off == 5'h00) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(bus_write_data[7:0]);
      end
      if (hit && off == 5'h10) m_irq_en = bus_write_data[0];
    end else if (bus_read_enable) begin
      if (!hit) m_rdata = 64'd0;
      else if (off == 5'h08) begin
        m_rdata = st;
        m_ovf   = 1'b0;
      end else if (off == 5'h10) m_rdata = {63'd0, m_irq_en};
      else m_rdata = 64'd0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("tx", 64'(tx), 64'(m_tx()));
    check_eq("irq", 64'(irq), 64'(m_irq()));
    check_eq("rdata", bus_read_data, m_rdata);
  endtask

  task automatic bus_idle();
    bus_address      = 64'd0;
    bus_write_data   = 64'd0;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [63:0] d);
    bus_address      = BASE | 64'(off);
    bus_write_data   = d;
    bus_write_enable = 1'b1;
    bus_read_enable  = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [4:0] off);
    bus_address      = BASE | 64'(off);
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (m_q.size() != 0 || m_left != 0); i++) step();
    check_eq("drain_done", 64'(m_q.size() + m_left), 64'd0);
  endtask

  initial begin
    int wprob;
    int pick;
    bus_idle();
    model_reset();
    reset = 1'b0;
    #23;
    check_eq("rst_tx", 64'(tx), 64'd1);
    check_eq("rst_irq", 64'(irq), 64'd0);
    check_eq("rst_rdata", bus_read_data, 64'd0);
    @(negedge clk) reset = 1'b1;

    idle(20);
    rd(5'h08);
    check_eq("status_after_reset", bus_read_data, 64'h2);

    // Single 0x55 frame and busy timing at the end of STOP.
    wr(5'h00, 64'h55);
    idle(40);
    rd(5'h08);
    check_eq("status_last_stop_cycle", bus_read_data, 64'h6);
    rd(5'h08);
    check_eq("status_after_frame", bus_read_data, 64'h2);

    wr(5'h00, 64'h41);
    wr(5'h00, 64'h42);
    wr(5'h00, 64'h43);
    rd(5'h08);
    check_eq("abc_count", 64'(bus_read_data[15:8]), 64'd2);
    drain();

    // 17 bytes fit because the first one is already in the shifter.
    for (int i = 0; i < 17; i++) wr(5'h00, 64'($urandom_range(0, 255)));
    rd(5'h08);
    check_eq("status_17_written", bus_read_data, 64'h1005);
    wr(5'h00, 64'hAA);
    wr(5'h00, 64'hBB);
    rd(5'h08);
    check_eq("status_overflow", bus_read_data, 64'h100D);
    rd(5'h08);
    check_eq("status_ovf_cleared", bus_read_data, 64'h1005);
    drain();

    wr(5'h10, 64'd1);
    rd(5'h10);
    check_eq("ctrl_readback", bus_read_data, 64'd1);
    wr(5'h00, 64'hA5);
    idle(5);
    check_eq("irq_in_frame", 64'(irq), 64'd0);
    drain();
    check_eq("irq_after_stop", 64'(irq), 64'd1);
    wr(5'h10, 64'd0);
    check_eq("irq_cleared", 64'(irq), 64'd0);

    // Reset during data bit 3 (byte 0xF0 drives tx low there).
    wr(5'h00, 64'hF0);
    wr(5'h00, 64'h3C);
    wr(5'h00, 64'h99);
    for (int i = 0; i < 100 && m_left != FRAME - 17; i++) step();
    check_eq("tx_bit3_low", 64'(tx), 64'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("tx_async_rst", 64'(tx), 64'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    rd(5'h08);
    check_eq("status_after_midrst", bus_read_data, 64'h2);
    idle(100);

    for (int blk = 0; blk < 8; blk++) begin
      wprob = $urandom_range(0, 12);
      for (int c = 0; c < 400; c++) begin
        pick = $urandom_range(0, 99);
        bus_write_data = {$urandom, $urandom};
        if (pick < wprob) begin
          bus_address      = BASE;
          bus_write_enable = 1'b1;
        end else if (pick < wprob + 5) begin
          bus_address     = BASE | 64'h08;
          bus_read_enable = 1'b1;
        end else if (pick < wprob + 7) begin
          bus_address      = BASE | 64'h10;
          bus_write_enable = 1'b1;
        end else if (pick < wprob + 9) begin
          bus_address     = BASE | 64'($urandom_range(0, 31));
          bus_read_enable = 1'b1;
        end else if (pick < wprob + 10) begin
          bus_address      = BASE ^ (64'd1 << $urandom_range(5, 63));
          bus_read_enable  = 1'b1;
          bus_write_enable = 1'($urandom_range(0, 1));
        end else if (pick < wprob + 11) begin
          bus_address      = BASE | 64'($urandom_range(0, 2) * 8);
          bus_read_enable  = 1'b1;
          bus_write_enable = 1'b1;
        end
        step();
        bus_idle();
      end
    end
    drain();
    rd(5'h08);
    check_eq("status_final", bus_read_data & 64'hFFFF_FFFF_FFFF_FFF7, 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
